// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo PWM generator family.
package servo_pkg;

    localparam int TICK_DIV_DEFAULT    = 195;
    localparam int MIN_TICKS_DEFAULT   = 256;
    localparam int FRAME_TICKS_DEFAULT = 5128;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic int pos_width(input int resolution);
        return (resolution < 1) ? 1 : resolution;
    endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Packed position bus with valid/ready handshake into the shadow registers.
interface servo_pwm_gen_if #(
    parameter int CHANNELS   = 18,
    parameter int RESOLUTION = 8
);
    logic [CHANNELS*RESOLUTION-1:0] servo_data;
    logic                           data_valid;
    logic                           data_ready;

    modport master (output servo_data, output data_valid, input  data_ready);
    modport slave  (input  servo_data, input  data_valid, output data_ready);
endinterface

// File: rtl/servo_tick_gen.sv
// Tick prescaler and frame counter; both held at zero while enable is low.
module servo_tick_gen import servo_pkg::*; #(
    parameter  int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter  int FRAME_TICKS = FRAME_TICKS_DEFAULT,
    localparam int TW          = clog2(TICK_DIV),
    localparam int FW          = clog2(FRAME_TICKS)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          enable,
    output logic          tick,
    output logic [FW-1:0] frame_cnt,
    output logic          frame_evt
);
    logic [TW-1:0] tick_cnt;

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign frame_evt = enable && (tick_cnt == '0) && (frame_cnt == '0);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            tick_cnt  <= '0;
            frame_cnt <= '0;
        end else if (!enable) begin
            tick_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick)
                frame_cnt <= (frame_cnt == FW'(FRAME_TICKS - 1)) ? '0 : frame_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Multi-channel servo PWM generator with frame-synchronous shadow->active transfer.
// Define SERVO_PWM_SLEW_EN to limit the per-frame position change to SLEW_STEP.
module servo_pwm_gen import servo_pkg::*; #(
    parameter int CHANNELS    = 18,
    parameter int RESOLUTION  = 8,
    parameter int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int MIN_TICKS   = MIN_TICKS_DEFAULT,
    parameter int FRAME_TICKS = FRAME_TICKS_DEFAULT,
    parameter int SLEW_STEP   = 1
) (
    input  logic                clk,
    input  logic                res,
    input  logic                enable,
    servo_pwm_gen_if.slave      bus,
    output logic                frame_start,
    output logic [CHANNELS-1:0] servo_signal
);
    localparam int FW = clog2(FRAME_TICKS);
    localparam int CW = FW + 1;
    localparam int PW = pos_width(RESOLUTION);
    localparam logic [PW-1:0] CENTRE = PW'(1 << (RESOLUTION - 1));

    if (CHANNELS < 1 || CHANNELS > 32 || TICK_DIV < 2 || MIN_TICKS < 1 || SLEW_STEP < 0 ||
        FRAME_TICKS <= MIN_TICKS + (1 << RESOLUTION) - 1) begin : g_bad_cfg
        $error("servo_pwm_gen: invalid parameter set");
    end

`ifdef SERVO_PWM_SLEW_EN
    // Clamping the step to the position range keeps active +/- STEP inside PW bits.
    localparam int STEP_MAX = (1 << RESOLUTION) - 1;
    localparam logic [PW-1:0] STEP = PW'((SLEW_STEP > STEP_MAX) ? STEP_MAX : SLEW_STEP);
`endif

    logic [FW-1:0] frame_cnt;
    logic          frame_evt;
    logic          wr;

    servo_tick_gen #(
        .TICK_DIV    (TICK_DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_tick (
        .clk       (clk),
        .res       (res),
        .enable    (enable),
        .tick      (),
        .frame_cnt (frame_cnt),
        .frame_evt (frame_evt)
    );

    // Writes are refused on the frame-event cycle so shadow and active never race.
    assign bus.data_ready = !res && !frame_evt;
    assign wr             = bus.data_valid && bus.data_ready;

    always_ff @(posedge clk or posedge res) begin
        if (res) frame_start <= 1'b0;
        else     frame_start <= frame_evt;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [PW-1:0] shadow;
        logic [PW-1:0] active;
        logic [PW-1:0] active_nxt;
        logic [CW-1:0] limit;
        logic          pwm;

        always_ff @(posedge clk or posedge res) begin
            if (res)     shadow <= CENTRE;
            else if (wr) shadow <= PW'(bus.servo_data[i*RESOLUTION +: RESOLUTION]);
        end

`ifdef SERVO_PWM_SLEW_EN
        always_comb begin
            active_nxt = active;
            if (shadow > active)
                active_nxt = (shadow - active > STEP) ? active + STEP : shadow;
            else if (active > shadow)
                active_nxt = (active - shadow > STEP) ? active - STEP : shadow;
        end
`else
        assign active_nxt = shadow;
`endif

        always_ff @(posedge clk or posedge res) begin
            if (res)            active <= CENTRE;
            else if (frame_evt) active <= active_nxt;
        end

        assign limit = CW'(MIN_TICKS) + CW'(active);

        always_ff @(posedge clk or posedge res) begin
            if (res) pwm <= 1'b0;
            else     pwm <= enable && ({1'b0, frame_cnt} < limit);
        end

        assign servo_signal[i] = pwm;
    end

endmodule
